ifu_axi_fetch: RTL

//  Parametrised instruction fetch unit with handshaked interfaces.
//  - Owns the PC register.
//  - Fetches one instruction per PC over an AXI4-Lite-style read channel (AR/R).
//  - Presents the instruction to the IDU with a valid/ready handshake.
//  - Accepts the next PC from the WBU with a valid/ready handshake.
//  - Sits between the WBU (pc_next) and the IDU; the combinational SRAM read path is replaced by a latency-tolerant bus master.

---
 rtl/ifu_axi_fetch.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ifu_axi_fetch.sv
// ifu_axi_fetch: PC owner and single-outstanding AXI4-Lite read master.
// Optional IFU_FAULT_EN: bus-error and misaligned-PC faults become NOPs.
module ifu_axi_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h8000_0000,
  parameter logic [DATA_W-1:0] NOP_INST = 'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  output logic              inst_valid,
  input  logic              inst_ready
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_ADDR,
    S_DATA,
    S_OUT,
    S_WAITPC
  } state_t;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_pc, w_pc;
  logic [ADDR_W-1:0]   r_araddr, w_araddr;
  logic                r_arvalid, w_arvalid;
  logic                r_rready, w_rready;
  logic [DATA_W-1:0]   r_inst, w_inst;
  logic [ADDR_W-1:0]   r_inst_pc, w_inst_pc;
  logic                r_inst_valid, w_inst_valid;
  logic                r_pc_ready, w_pc_ready;
`ifdef IFU_FAULT_EN
  logic                r_fault, w_fault;
`else
  logic                w_unused_rresp;
`endif

  // State and registered outputs; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_araddr     <= RESET_PC;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_pc_ready   <= 1'b0;
`ifdef IFU_FAULT_EN
      r_fault      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_araddr     <= w_araddr;
      r_arvalid    <= w_arvalid;
      r_rready     <= w_rready;
      r_inst       <= w_inst;
      r_inst_pc    <= w_inst_pc;
      r_inst_valid <= w_inst_valid;
      r_pc_ready   <= w_pc_ready;
`ifdef IFU_FAULT_EN
      r_fault      <= w_fault;
`endif
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_araddr     = r_araddr;
    w_arvalid    = r_arvalid;
    w_rready     = r_rready;
    w_inst       = r_inst;
    w_inst_pc    = r_inst_pc;
    w_inst_valid = r_inst_valid;
    w_pc_ready   = r_pc_ready;
`ifdef IFU_FAULT_EN
    w_fault      = r_fault;
`endif
    unique case (r_state)
      S_BOOT: begin
        w_araddr  = r_pc;
        w_arvalid = 1'b1;
        w_state   = S_ADDR;
      end
      S_ADDR: begin
        if (arready) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = S_DATA;
        end
      end
      S_DATA: begin
        if (rvalid) begin
          w_inst       = rdata;
          w_inst_pc    = r_pc;
          w_rready     = 1'b0;
          w_inst_valid = 1'b1;
          w_state      = S_OUT;
`ifdef IFU_FAULT_EN
          w_fault      = (rresp != 2'b00);
          if (rresp != 2'b00) w_inst = NOP_INST;
`endif
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          w_inst_valid = 1'b0;
          w_pc_ready   = 1'b1;
          w_state      = S_WAITPC;
        end
      end
      S_WAITPC: begin
        if (pc_valid) begin
          w_pc_ready = 1'b0;
          w_pc       = pc_next;
          w_araddr   = pc_next;
`ifdef IFU_FAULT_EN
          if (pc_next[1:0] != 2'b00) begin
            w_inst       = NOP_INST;
            w_inst_pc    = pc_next;
            w_fault      = 1'b1;
            w_inst_valid = 1'b1;
            w_state      = S_OUT;
          end else begin
            w_arvalid = 1'b1;
            w_state   = S_ADDR;
          end
`else
          w_arvalid = 1'b1;
          w_state   = S_ADDR;
`endif
        end
      end
      default: w_state = S_BOOT;
    endcase
  end

`ifdef IFU_FAULT_EN
  assign inst_fault = r_fault;
`else
  assign inst_fault     = 1'b0;
  assign w_unused_rresp = ^rresp;
`endif

  assign pc_ready   = r_pc_ready;
  assign araddr     = r_araddr;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;

endmodule
